instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the instruction register. Owns the program counter,

---
 rtl/cpu_defs.sv | 22 ++
 rtl/program_counter.sv | 36 +++
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: default widths, fetch FSM encoding and the halt opcode.
// Pure declarations, so no latency or backpressure applies.
package cpu_defs;

  localparam int DEF_INSTR_W = 15;
  localparam int DEF_ADDR_W  = 8;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH   = ST_FETCH,
    S_WAIT    = ST_WAIT,
    S_DELIVER = ST_DELIVER,
    S_HALTED  = ST_HALTED
  } fetch_state_e;

  localparam logic [DEF_INSTR_W-1:0] HALT_OPCODE = {DEF_INSTR_W{1'b1}};

endpackage

// File: rtl/program_counter.sv
// Program counter register: load (jump) has priority over inc, wraps modulo 2^ADDR_W.
// Updates one cycle after load/inc; no backpressure of its own.
module program_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one ROM read in flight, strobe MEM_LAT+1 cycles after issue, stall gates issue only.
// FETCH_HALT_EN adds a HALTED state (entered after delivering an all-ones word) and a halted port.
module instruction_fetch
  import cpu_defs::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_load,
  output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_HALT_EN
  ,
  output logic               halted
`endif
);

  localparam int LAT_W = 2;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
`ifdef FETCH_HALT_EN
  localparam logic [INSTR_W-1:0] HALT_WORD = {INSTR_W{1'b1}};
`endif

  fetch_state_e       state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]  pc;
  logic               issue;
  logic               capture;

  program_counter #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .inc     (capture),
    .load    (jump_en),
    .load_val(jump_addr),
    .pc      (pc)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    issue     = 1'b0;
    capture   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!stall) begin
          issue     = 1'b1;
          lat_cnt_d = LAT_INIT;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_DELIVER;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_DELIVER: begin
        state_d = S_FETCH;
`ifdef FETCH_HALT_EN
        if (instr_q == HALT_WORD) begin
          state_d = S_HALTED;
        end
`endif
      end
`ifdef FETCH_HALT_EN
      S_HALTED: begin
        state_d = S_HALTED;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // A jump cancels both a fetch about to issue and data about to be captured.
    if (jump_en) begin
      state_d = S_FETCH;
      issue   = 1'b0;
      capture = 1'b0;
    end

    if (capture) begin
      instr_d  = mem_rdata;
      pc_out_d = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      lat_cnt_q <= '0;
      instr_q   <= '0;
      pc_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign mem_rd     = issue & ~reset;
  assign mem_addr   = pc;
  assign instr_out  = instr_q;
  assign instr_load = (state_q == S_DELIVER);
  assign pc_out     = pc_out_q;
`ifdef FETCH_HALT_EN
  assign halted     = (state_q == S_HALTED);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: DUT A with MEM_LAT=1, DUT B with MEM_LAT=3, ROM[i]=i+100.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit halt_armed = 1'b0;

  logic        a_stall = 1'b0, a_jump_en = 1'b0;
  logic [7:0]  a_jump_addr = 8'd0;
  logic [14:0] a_rdata = 15'd0;
  logic        a_mem_rd, a_instr_load;
  logic [7:0]  a_mem_addr, a_pc_out;
  logic [14:0] a_instr_out;

  logic        b_stall = 1'b0, b_jump_en = 1'b0;
  logic [7:0]  b_jump_addr = 8'd0;
  logic [14:0] b_rdata = 15'd0, b_p0 = 15'd0, b_p1 = 15'd0;
  logic        b_mem_rd, b_instr_load;
  logic [7:0]  b_mem_addr, b_pc_out;
  logic [14:0] b_instr_out;
`ifdef FETCH_HALT_EN
  logic        a_halted, b_halted;
`endif

  // Synchronous ROMs: A answers one cycle after the address, B three cycles after.
  always @(posedge clk) begin
    a_rdata <= (halt_armed && a_mem_addr == 8'd5) ? 15'h7FFF : {7'd0, a_mem_addr} + 15'd100;
    b_p0    <= {7'd0, b_mem_addr} + 15'd100;
    b_p1    <= b_p0;
    b_rdata <= b_p1;
  end

  instruction_fetch #(.ADDR_W(8), .INSTR_W(15), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .stall(a_stall), .jump_en(a_jump_en), .jump_addr(a_jump_addr), .instr_out(a_instr_out),
    .instr_load(a_instr_load), .pc_out(a_pc_out)
`ifdef FETCH_HALT_EN
    , .halted(a_halted)
`endif
  );

  instruction_fetch #(.ADDR_W(8), .INSTR_W(15), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .stall(b_stall), .jump_en(b_jump_en), .jump_addr(b_jump_addr), .instr_out(b_instr_out),
    .instr_load(b_instr_load), .pc_out(b_pc_out)
`ifdef FETCH_HALT_EN
    , .halted(b_halted)
`endif
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_mem_rd !== 1'b0) begin errors++; $display("FAIL reset_a_mem_rd: got %b want 0", a_mem_rd); end
    checks++; if (a_instr_load !== 1'b0) begin errors++; $display("FAIL reset_a_load: got %b want 0", a_instr_load); end
    checks++; if (a_instr_out !== 15'd0) begin errors++; $display("FAIL reset_a_instr: got %0d want 0", a_instr_out); end
    checks++; if (a_pc_out !== 8'd0) begin errors++; $display("FAIL reset_a_pc_out: got %0d want 0", a_pc_out); end
    checks++; if (a_mem_addr !== 8'd0) begin errors++; $display("FAIL reset_a_addr: got %0d want 0", a_mem_addr); end
    checks++; if (b_mem_rd !== 1'b0) begin errors++; $display("FAIL reset_b_mem_rd: got %b want 0", b_mem_rd); end
    checks++; if (b_instr_load !== 1'b0) begin errors++; $display("FAIL reset_b_load: got %b want 0", b_instr_load); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int got = 0;
    int last_c = -1;
    bit prev_rd;
    #1;
    checks++; if (a_mem_rd !== 1'b1 || a_mem_addr !== 8'd0) begin
      errors++; $display("FAIL basic_first_fetch: rd=%b addr=%0d want rd=1 addr=0", a_mem_rd, a_mem_addr);
    end
    prev_rd = a_mem_rd;
    for (int c = 0; c < 12 && got < 3; c++) begin
      @(negedge clk);
      if (a_mem_rd) begin
        checks++; if (prev_rd) begin errors++; $display("FAIL basic_rd_b2b: mem_rd high two cycles at c=%0d", c); end
      end
      prev_rd = a_mem_rd;
      if (a_instr_load) begin
        checks++; if (a_instr_out !== 15'(100 + got)) begin errors++; $display("FAIL basic_instr%0d: got %0d want %0d", got, a_instr_out, 100 + got); end
        checks++; if (a_pc_out !== 8'(got)) begin errors++; $display("FAIL basic_pc%0d: got %0d want %0d", got, a_pc_out, got); end
        checks++;
        if (got == 0 && c != 1) begin errors++; $display("FAIL basic_latency: got %0d want 1", c); end
        else if (got > 0 && c - last_c != 3) begin errors++; $display("FAIL basic_period: got %0d want 3", c - last_c); end
        last_c = c;
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL basic_count: got %0d strobes want 3", got); end
  endtask

  task automatic test_mem_lat3();
    int rd_c = -1, last_ld = -1, n_ld = 0;
    logic [7:0] last_pc = 8'd0;
    bit prev_rd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_mem_rd) begin
        checks++; if (prev_rd) begin errors++; $display("FAIL lat3_rd_b2b: mem_rd high two cycles at c=%0d", c); end
        rd_c = c;
      end
      prev_rd = b_mem_rd;
      if (b_instr_load) begin
        checks++; if (b_instr_out !== {7'd0, b_pc_out} + 15'd100) begin
          errors++; $display("FAIL lat3_data: got %0d want %0d", b_instr_out, {7'd0, b_pc_out} + 15'd100);
        end
        if (rd_c >= 0) begin
          checks++; if (c - rd_c != 4) begin errors++; $display("FAIL lat3_latency: got %0d want 4", c - rd_c); end
        end
        if (last_ld >= 0) begin
          checks++; if (c - last_ld != 5) begin errors++; $display("FAIL lat3_period: got %0d want 5", c - last_ld); end
          checks++; if (b_pc_out !== last_pc + 8'd1) begin errors++; $display("FAIL lat3_pc_seq: got %0d want %0d", b_pc_out, last_pc + 8'd1); end
        end
        last_ld = c;
        last_pc = b_pc_out;
        n_ld++;
      end
    end
    checks++; if (n_ld < 7) begin errors++; $display("FAIL lat3_count: got %0d strobes want >=7", n_ld); end
  endtask

  task automatic test_jump_wait();
    bit found = 1'b0;
    int ld_at = -1;
    logic [14:0] old_i;
    logic [7:0]  old_p;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (a_mem_rd) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL jump_find_rd: got no mem_rd want one within 10 cycles"); end
    old_i = a_instr_out;
    old_p = a_pc_out;
    @(negedge clk);
    a_jump_en = 1'b1;
    a_jump_addr = 8'h40;
    @(posedge clk); #1 a_jump_en = 1'b0;
    @(negedge clk);
    checks++; if (a_instr_load !== 1'b0) begin errors++; $display("FAIL jump_no_strobe: got %b want 0", a_instr_load); end
    checks++; if (a_mem_rd !== 1'b1 || a_mem_addr !== 8'h40) begin errors++; $display("FAIL jump_refetch: rd=%b addr=%h want rd=1 addr=40", a_mem_rd, a_mem_addr); end
    checks++; if (a_instr_out !== old_i || a_pc_out !== old_p) begin
      errors++; $display("FAIL jump_hold: instr=%0d pc=%0d want instr=%0d pc=%0d", a_instr_out, a_pc_out, old_i, old_p);
    end
    for (int i = 0; i < 6 && ld_at < 0; i++) begin
      @(negedge clk);
      if (a_instr_load) ld_at = i;
    end
    checks++; if (ld_at != 1) begin errors++; $display("FAIL jump_strobe_time: got %0d want 1", ld_at); end
    checks++; if (a_instr_out !== 15'd164 || a_pc_out !== 8'h40) begin
      errors++; $display("FAIL jump_data: instr=%0d pc=%h want instr=164 pc=40", a_instr_out, a_pc_out);
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    int n_ld = 0;
    logic [7:0]  a;
    logic [14:0] exp_i;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (a_mem_rd) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_find_rd: got no mem_rd want one within 10 cycles"); end
    a = a_mem_addr;
    exp_i = {7'd0, a} + 15'd100;
    @(posedge clk); #1 a_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (a_mem_rd !== 1'b0) begin errors++; $display("FAIL stall_rd%0d: got %b want 0", i, a_mem_rd); end
      if (a_instr_load) begin
        n_ld++;
        checks++; if (a_instr_out !== exp_i || a_pc_out !== a) begin
          errors++; $display("FAIL stall_data: instr=%0d pc=%0d want instr=%0d pc=%0d", a_instr_out, a_pc_out, exp_i, a);
        end
      end
    end
    checks++; if (n_ld != 1) begin errors++; $display("FAIL stall_strobes: got %0d want 1", n_ld); end
    @(posedge clk); #1 a_stall = 1'b0;
    @(negedge clk);
    checks++; if (a_mem_rd !== 1'b1 || a_mem_addr !== a + 8'd1) begin
      errors++; $display("FAIL stall_resume: rd=%b addr=%0d want rd=1 addr=%0d", a_mem_rd, a_mem_addr, a + 8'd1);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    a_jump_en = 1'b1;
    a_jump_addr = 8'hFF;
    @(posedge clk); #1 a_jump_en = 1'b0;
    @(negedge clk);
    checks++; if (a_mem_rd !== 1'b1 || a_mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_fetch_ff: rd=%b addr=%h want rd=1 addr=ff", a_mem_rd, a_mem_addr); end
    for (int i = 0; i < 12 && n < 2; i++) begin
      @(negedge clk);
      if (a_mem_rd && n == 1) begin
        checks++; if (a_mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_fetch_00: got %h want 00", a_mem_addr); end
      end
      if (a_instr_load) begin
        checks++;
        if (n == 0 && (a_pc_out !== 8'hFF || a_instr_out !== 15'd355)) begin
          errors++; $display("FAIL wrap_word_ff: pc=%h instr=%0d want pc=ff instr=355", a_pc_out, a_instr_out);
        end else if (n == 1 && (a_pc_out !== 8'h00 || a_instr_out !== 15'd100)) begin
          errors++; $display("FAIL wrap_word_00: pc=%h instr=%0d want pc=00 instr=100", a_pc_out, a_instr_out);
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL wrap_count: got %0d strobes want 2", n); end
  endtask

  task automatic test_jump_stall();
    int ld_at = -1;
    @(posedge clk); #1;
    a_stall = 1'b1;
    a_jump_en = 1'b1;
    a_jump_addr = 8'h20;
    @(posedge clk); #1 a_jump_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_mem_rd !== 1'b0 || a_instr_load !== 1'b0) begin
        errors++; $display("FAIL jstall_idle%0d: rd=%b load=%b want 0 0", i, a_mem_rd, a_instr_load);
      end
    end
    @(posedge clk); #1 a_stall = 1'b0;
    @(negedge clk);
    checks++; if (a_mem_rd !== 1'b1 || a_mem_addr !== 8'h20) begin errors++; $display("FAIL jstall_fetch: rd=%b addr=%h want rd=1 addr=20", a_mem_rd, a_mem_addr); end
    for (int i = 0; i < 6 && ld_at < 0; i++) begin
      @(negedge clk);
      if (a_instr_load) ld_at = i;
    end
    checks++; if (ld_at != 1 || a_pc_out !== 8'h20 || a_instr_out !== 15'd132) begin
      errors++; $display("FAIL jstall_data: at=%0d pc=%h instr=%0d want at=1 pc=20 instr=132", ld_at, a_pc_out, a_instr_out);
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    int n = 0;
    halt_armed = 1'b1;
    @(posedge clk); #1;
    a_jump_en = 1'b1;
    a_jump_addr = 8'h00;
    @(posedge clk); #1 a_jump_en = 1'b0;
    for (int i = 0; i < 30 && n < 6; i++) begin
      @(negedge clk);
      if (a_instr_load) begin
        checks++; if (a_pc_out !== 8'(n) || a_instr_out !== ((n == 5) ? 15'h7FFF : 15'(100 + n))) begin
          errors++; $display("FAIL halt_word%0d: pc=%0d instr=%h", n, a_pc_out, a_instr_out);
        end
        n++;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL halt_count: got %0d strobes want 6", n); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (a_halted !== 1'b1 || a_mem_rd !== 1'b0) begin
        errors++; $display("FAIL halt_hold%0d: halted=%b rd=%b want 1 0", i, a_halted, a_mem_rd);
      end
    end
    @(posedge clk); #1 a_jump_en = 1'b1;
    @(posedge clk); #1 a_jump_en = 1'b0;
    @(negedge clk);
    checks++; if (a_halted !== 1'b0 || a_mem_rd !== 1'b1 || a_mem_addr !== 8'h00) begin
      errors++; $display("FAIL halt_exit: halted=%b rd=%b addr=%h want 0 1 00", a_halted, a_mem_rd, a_mem_addr);
    end
    halt_armed = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mem_lat3();
    test_jump_wait();
    test_stall();
    test_wrap();
    test_jump_stall();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
